// File: rtl/ecc32_pkg.sv
// Shared SECDED definitions for the ecc32 encoder/decoder pair: H-matrix
// column placement, check-bit generation and syndrome-to-data-bit lookup.
package ecc32_pkg;

   localparam logic [1:0] ECC_OK    = 2'd0;
   localparam logic [1:0] ECC_DFIX  = 2'd1;
   localparam logic [1:0] ECC_CFIX  = 2'd2;
   localparam logic [1:0] ECC_UNCOR = 2'd3;

   // Hamming position of data bit idx; powers of two are reserved for check bits.
   function automatic logic [5:0] ecc32_bitpos(input logic [4:0] idx);
      logic [5:0] pos;
      if (idx == 5'd0)       pos = 6'd3;
      else if (idx < 5'd4)   pos = {1'b0, idx} + 6'd4;
      else if (idx < 5'd11)  pos = {1'b0, idx} + 6'd5;
      else if (idx < 5'd26)  pos = {1'b0, idx} + 6'd6;
      else                   pos = {1'b0, idx} + 6'd7;
      return pos;
   endfunction

   function automatic logic [5:0] ecc32_chk(input logic [31:0] data);
      logic [5:0] chk;
      chk = 6'd0;
      for (int i = 0; i < 32; i++) begin
         if (data[i]) chk = chk ^ ecc32_bitpos(5'(i));
      end
      return chk;
   endfunction

   // Returns {hit, index}: hit is set when the syndrome names a data column.
   function automatic logic [5:0] ecc32_pos2bit(input logic [5:0] syndrome);
      logic [5:0] res;
      res = 6'd0;
      for (int i = 0; i < 32; i++) begin
         if (ecc32_bitpos(5'(i)) == syndrome) res = {1'b1, 5'(i)};
      end
      return res;
   endfunction

endpackage

// File: rtl/ecc32_syndrome.sv
// Combinational syndrome and overall-parity computation for one received word.
module ecc32_syndrome
   import ecc32_pkg::*;
(
   input  logic [31:0] data,
   input  logic [6:0]  parity,
   output logic [5:0]  syndrome,
   output logic        ovp
);

   assign syndrome = ecc32_chk(data) ^ parity[5:0];
   assign ovp      = ^{data, parity};

endmodule

// File: rtl/ecc32_decoder.sv
// Two-stage SECDED decoder: syndrome in stage 1, correction/classification and
// saturating error statistics in stage 2.
module ecc32_decoder
   import ecc32_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic             clock,
   input  logic             reset_n,
   input  logic [31:0]      dec_in,
   input  logic [6:0]       parity_in,
   input  logic             in_valid,
   input  logic             cnt_clear,
   output logic [31:0]      dec_out,
   output logic [6:0]       syndrome_out,
   output logic [1:0]       err_type,
   output logic             out_valid,
   output logic [CNT_W-1:0] sbe_count,
   output logic [CNT_W-1:0] dbe_count,
   output logic             sbe_sticky,
   output logic             dbe_sticky
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   logic [5:0]  syn_p0;
   logic        ovp_p0;
   logic [31:0] data_p1;
   logic [5:0]  syn_p1;
   logic        ovp_p1;
   logic        vld_p1;
   logic [5:0]  hit_p1;
   logic [31:0] fix_p1;
   logic [1:0]  err_p1;

   ecc32_syndrome u_syndrome (
      .data     (dec_in),
      .parity   (parity_in),
      .syndrome (syn_p0),
      .ovp      (ovp_p0)
   );

   // Stage 1: received word and its syndrome
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) vld_p1 <= 1'b0;
      else          vld_p1 <= in_valid;
   end

   always_ff @(posedge clock) begin
      if (in_valid) begin
         data_p1 <= dec_in;
         syn_p1  <= syn_p0;
         ovp_p1  <= ovp_p0;
      end
   end

   assign hit_p1 = ecc32_pos2bit(syn_p1);

   always_comb begin
      err_p1 = ECC_OK;
      fix_p1 = data_p1;
      if (syn_p1 == 6'd0) begin
         err_p1 = ovp_p1 ? ECC_CFIX : ECC_OK;
      end else if (!ovp_p1) begin
         err_p1 = ECC_UNCOR;
      end else if ((syn_p1 & (syn_p1 - 6'd1)) == 6'd0) begin
         err_p1 = ECC_CFIX;
      end else if (hit_p1[5]) begin
         err_p1 = ECC_DFIX;
         fix_p1[hit_p1[4:0]] = ~data_p1[hit_p1[4:0]];
      end else begin
         // Syndromes past the last data column can only come from 3+ flips
         err_p1 = ECC_UNCOR;
      end
   end

   // Stage 2: corrected word, classification and error statistics
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dec_out      <= 32'd0;
         syndrome_out <= 7'd0;
         err_type     <= ECC_OK;
         out_valid    <= 1'b0;
      end else begin
         out_valid <= vld_p1;
         if (vld_p1) begin
            dec_out      <= fix_p1;
            syndrome_out <= {ovp_p1, syn_p1};
            err_type     <= err_p1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sbe_count  <= '0;
         dbe_count  <= '0;
         sbe_sticky <= 1'b0;
         dbe_sticky <= 1'b0;
      end else if (cnt_clear) begin
         sbe_count  <= '0;
         dbe_count  <= '0;
         sbe_sticky <= 1'b0;
         dbe_sticky <= 1'b0;
      end else if (vld_p1) begin
         if (err_p1 == ECC_DFIX || err_p1 == ECC_CFIX) begin
            sbe_count  <= sat_inc(sbe_count);
            sbe_sticky <= 1'b1;
         end
         if (err_p1 == ECC_UNCOR) begin
            dbe_count  <= sat_inc(dbe_count);
            dbe_sticky <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ecc32_decoder.sv
// Scoreboard bench for ecc32_decoder built with 4-bit counters so saturation is reachable.
module tb_ecc32_decoder;

   localparam int CNT_W = 4;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic [31:0]      dec_in = '0;
   logic [6:0]       parity_in = '0;
   logic             in_valid = 1'b0;
   logic             cnt_clear = 1'b0;
   logic [31:0]      dec_out;
   logic [6:0]       syndrome_out;
   logic [1:0]       err_type;
   logic             out_valid;
   logic [CNT_W-1:0] sbe_count;
   logic [CNT_W-1:0] dbe_count;
   logic             sbe_sticky;
   logic             dbe_sticky;

   ecc32_decoder #(.CNT_W(CNT_W)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .dec_in       (dec_in),
      .parity_in    (parity_in),
      .in_valid     (in_valid),
      .cnt_clear    (cnt_clear),
      .dec_out      (dec_out),
      .syndrome_out (syndrome_out),
      .err_type     (err_type),
      .out_valid    (out_valid),
      .sbe_count    (sbe_count),
      .dbe_count    (dbe_count),
      .sbe_sticky   (sbe_sticky),
      .dbe_sticky   (dbe_sticky)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] d;
      logic [6:0]  syn;
      logic [1:0]  et;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int n_checks = 0;
   int n_fail = 0;

   // n-th non-power-of-two position, found by walking the position space
   function automatic int tb_pos(input int i);
      int n;
      int res;
      n = -1;
      res = 0;
      for (int p = 1; p < 64; p++) begin
         if ((p & (p - 1)) != 0) begin
            n++;
            if (n == i) res = p;
         end
      end
      return res;
   endfunction

   function automatic logic [6:0] tb_encode(input logic [31:0] d);
      logic [5:0] c;
      int p;
      c = 6'd0;
      for (int i = 0; i < 32; i++) begin
         if (d[i]) begin
            p = tb_pos(i);
            c = c ^ p[5:0];
         end
      end
      return {(^d) ^ (^c), c};
   endfunction

   function automatic logic [6:0] tb_dsyn(input int b);
      int p;
      p = tb_pos(b);
      return {1'b1, p[5:0]};
   endfunction

   task automatic send(input logic [31:0] d, input logic [6:0] p, input logic [31:0] ed,
                       input logic [6:0] esyn, input logic [1:0] eet, input bit push);
      exp_t e;
      dec_in    = d;
      parity_in = p;
      in_valid  = 1'b1;
      if (push) begin
         e = '{ed, esyn, eet, cyc + 2};
         sb.push_back(e);
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 20) begin
         @(negedge clock);
         k++;
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d words outstanding, required 0", sb.size());
         sb.delete();
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_checks += 8;
      if (dec_out !== 32'd0)     begin n_fail++; $display("FAIL rst_dec_out: got %h want 0", dec_out); end
      if (syndrome_out !== 7'd0) begin n_fail++; $display("FAIL rst_syndrome: got %h want 0", syndrome_out); end
      if (err_type !== 2'd0)     begin n_fail++; $display("FAIL rst_err_type: got %0d want 0", err_type); end
      if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      if (sbe_count !== '0)      begin n_fail++; $display("FAIL rst_sbe_count: got %0d want 0", sbe_count); end
      if (dbe_count !== '0)      begin n_fail++; $display("FAIL rst_dbe_count: got %0d want 0", dbe_count); end
      if (sbe_sticky !== 1'b0)   begin n_fail++; $display("FAIL rst_sbe_sticky: got %b want 0", sbe_sticky); end
      if (dbe_sticky !== 1'b0)   begin n_fail++; $display("FAIL rst_dbe_sticky: got %b want 0", dbe_sticky); end
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_clean();
      send(32'h0, 7'h00, 32'h0, 7'h00, 2'd0, 1);
      send(32'hDEADBEEF, tb_encode(32'hDEADBEEF), 32'hDEADBEEF, 7'h00, 2'd0, 1);
      drain();
      n_checks++;
      if (sbe_count !== '0 || dbe_count !== '0) begin
         n_fail++;
         $display("FAIL clean_counts: sbe=%0d dbe=%0d want 0/0", sbe_count, dbe_count);
      end
   endtask

   task automatic test_single_data();
      logic [31:0] d;
      d = 32'hDEADBEEF;
      send(d ^ 32'h1, tb_encode(d), d, 7'h43, 2'd1, 1);
      drain();
      n_checks += 3;
      if (sbe_count !== 4'd1)  begin n_fail++; $display("FAIL sbe_count_1: got %0d want 1", sbe_count); end
      if (sbe_sticky !== 1'b1) begin n_fail++; $display("FAIL sbe_sticky_set: got %b want 1", sbe_sticky); end
      if (dbe_sticky !== 1'b0) begin n_fail++; $display("FAIL dbe_sticky_clear: got %b want 0", dbe_sticky); end
   endtask

   task automatic test_check_bits();
      logic [31:0] d;
      d = 32'hDEADBEEF;
      send(d, tb_encode(d) ^ 7'h40, d, 7'h40, 2'd2, 1);
      send(d, tb_encode(d) ^ 7'h20, d, 7'h60, 2'd2, 1);
      drain();
      n_checks++;
      if (sbe_count !== 4'd3) begin n_fail++; $display("FAIL sbe_count_3: got %0d want 3", sbe_count); end
   endtask

   task automatic test_double();
      logic [31:0] d;
      logic [31:0] rx;
      d  = 32'h12345678;
      rx = d ^ 32'h3;
      send(rx, tb_encode(d), rx, 7'h06, 2'd3, 1);
      drain();
      n_checks += 2;
      if (dbe_count !== 4'd1)  begin n_fail++; $display("FAIL dbe_count_1: got %0d want 1", dbe_count); end
      if (dbe_sticky !== 1'b1) begin n_fail++; $display("FAIL dbe_sticky_set: got %b want 1", dbe_sticky); end
      // data bit 31 (position 38) plus check bits 0 and 6: syndrome 0x27 lies beyond every data column
      rx = d ^ 32'h8000_0000;
      send(rx, tb_encode(d) ^ 7'h41, rx, 7'h67, 2'd3, 1);
      drain();
      n_checks++;
      if (dbe_count !== 4'd2) begin n_fail++; $display("FAIL dbe_count_2: got %0d want 2", dbe_count); end
   endtask

   task automatic test_hold();
      logic [31:0] hd;
      logic [6:0]  hs;
      logic [1:0]  he;
      logic [CNT_W-1:0] hsb;
      logic [CNT_W-1:0] hdb;
      hd = dec_out; hs = syndrome_out; he = err_type; hsb = sbe_count; hdb = dbe_count;
      dec_in = 32'hFFFF_0000;
      parity_in = 7'h7F;
      repeat (5) @(posedge clock);
      @(negedge clock);
      n_checks += 3;
      if (dec_out !== hd || syndrome_out !== hs || err_type !== he) begin
         n_fail++;
         $display("FAIL hold_outputs: got %h/%h/%0d want %h/%h/%0d", dec_out, syndrome_out, err_type, hd, hs, he);
      end
      if (sbe_count !== hsb) begin n_fail++; $display("FAIL hold_sbe: got %0d want %0d", sbe_count, hsb); end
      if (dbe_count !== hdb) begin n_fail++; $display("FAIL hold_dbe: got %0d want %0d", dbe_count, hdb); end
      @(posedge clock);
      #1;
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      int b;
      cnt_clear = 1'b1;
      @(posedge clock);
      #1;
      cnt_clear = 1'b0;
      n_checks += 2;
      if (sbe_count !== '0 || dbe_count !== '0) begin
         n_fail++;
         $display("FAIL clear_counts: sbe=%0d dbe=%0d want 0/0", sbe_count, dbe_count);
      end
      if (sbe_sticky !== 1'b0 || dbe_sticky !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_sticky: sbe=%b dbe=%b want 0/0", sbe_sticky, dbe_sticky);
      end
      for (int i = 0; i < 17; i++) begin
         d = $urandom;
         b = $urandom_range(0, 31);
         send(d ^ (32'h1 << b), tb_encode(d), d, tb_dsyn(b), 2'd1, 1);
      end
      drain();
      n_checks++;
      if (sbe_count !== 4'd15) begin n_fail++; $display("FAIL sbe_saturate: got %0d want 15", sbe_count); end
      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         b = $urandom_range(0, 31);
         if (i % 2 == 0) send(d, tb_encode(d), d, 7'h00, 2'd0, 1);
         else            send(d ^ (32'h1 << b), tb_encode(d), d, tb_dsyn(b), 2'd1, 1);
         repeat ($urandom_range(0, 2)) @(posedge clock);
         #1;
      end
      drain();
   endtask

   task automatic test_clear_collision();
      logic [31:0] d;
      d = 32'hCAFE0123;
      send(d ^ 32'h0001_0000, tb_encode(d), d, tb_dsyn(16), 2'd1, 1);
      cnt_clear = 1'b1;
      @(posedge clock);
      #1;
      cnt_clear = 1'b0;
      n_checks += 2;
      if (sbe_count !== '0)    begin n_fail++; $display("FAIL clear_collision_cnt: got %0d want 0", sbe_count); end
      if (sbe_sticky !== 1'b0) begin n_fail++; $display("FAIL clear_collision_sticky: got %b want 0", sbe_sticky); end
      drain();
   endtask

   task automatic test_reset_midstream();
      logic [31:0] d;
      d = 32'h0BAD_F00D;
      send(d ^ 32'h3, tb_encode(d), d ^ 32'h3, 7'h06, 2'd3, 1);
      drain();
      send(32'h1111_1111, tb_encode(32'h1111_1111), 32'h0, 7'h0, 2'd0, 0);
      dec_in    = 32'h2222_2222;
      parity_in = tb_encode(32'h2222_2222);
      in_valid  = 1'b1;
      reset_n   = 1'b0;
      @(negedge clock);
      n_checks += 3;
      if (out_valid !== 1'b0 || dec_out !== 32'd0 || syndrome_out !== 7'd0 || err_type !== 2'd0) begin
         n_fail++;
         $display("FAIL midrst_outputs: ov=%b dec=%h syn=%h et=%0d want all 0", out_valid, dec_out, syndrome_out, err_type);
      end
      if (dbe_count !== '0 || sbe_count !== '0) begin
         n_fail++;
         $display("FAIL midrst_counts: sbe=%0d dbe=%0d want 0/0", sbe_count, dbe_count);
      end
      if (dbe_sticky !== 1'b0 || sbe_sticky !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_sticky: sbe=%b dbe=%b want 0/0", sbe_sticky, dbe_sticky);
      end
      @(posedge clock);
      #1;
      reset_n  = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         n_checks++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_flushed_%0d: out_valid=%b want 0", i, out_valid); end
      end
      @(posedge clock);
      #1;
      d = 32'h5A5A_A5A5;
      send(d ^ 32'h0400_0000, tb_encode(d), d, tb_dsyn(26), 2'd1, 1);
      drain();
      n_checks++;
      if (sbe_count !== 4'd1) begin n_fail++; $display("FAIL post_rst_sbe: got %0d want 1", sbe_count); end
   endtask

   initial begin
      fork
         begin : monitor
            exp_t e;
            forever begin
               @(negedge clock);
               if (reset_n && out_valid) begin
                  n_checks++;
                  if (sb.size() == 0) begin
                     n_fail++;
                     $display("FAIL unexpected_out_valid: cycle %0d dec_out=%h, no word expected", cyc, dec_out);
                  end else begin
                     e = sb.pop_front();
                     if (dec_out !== e.d || syndrome_out !== e.syn || err_type !== e.et || cyc !== e.cyc) begin
                        n_fail++;
                        $display("FAIL word: got dec=%h syn=%h et=%0d cyc=%0d want dec=%h syn=%h et=%0d cyc=%0d",
                                 dec_out, syndrome_out, err_type, cyc, e.d, e.syn, e.et, e.cyc);
                     end
                  end
               end
            end
         end
      join_none

      test_reset();
      test_clean();
      test_single_data();
      test_check_bits();
      test_double();
      test_hold();
      test_back_to_back();
      test_clear_collision();
      test_reset_midstream();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ecc32_decoder.md
# ecc32_decoder

Pipelined SECDED decoder for 32-bit data words protected by 7 Hamming check bits (6 position bits plus 1 overall parity bit). It sits on the receive side of the ALCT data path, opposite the existing ecc32 check-bit generator. It recomputes the check bits and forms a syndrome, corrects any single-bit error, and flags double-bit errors. It also keeps saturating single-error and double-error counters for VME readout.

## Interface
Parameters:
- CNT_W, default 16: width of each error counter.

Ports:
- clock  in  1  single system clock; all state is updated on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dec_in  in  32  received data word.
- parity_in  in  7  received check bits. Bits [5:0] are position bits; bit [6] is the overall parity bit.
- in_valid  in  1  dec_in and parity_in are valid this cycle.
- cnt_clear  in  1  synchronous clear of both counters and the sticky flags.
- dec_out  out  32  corrected data word.
- syndrome_out  out  7  {overall parity mismatch, syndrome[5:0]}.
- err_type  out  2  0 = clean; 1 = data bit corrected; 2 = check bit in error (data unchanged); 3 = uncorrectable.
- out_valid  out  1  dec_out, syndrome_out and err_type are valid this cycle.
- sbe_count  out  CNT_W  saturating count of words with err_type 1 or 2.
- dbe_count  out  CNT_W  saturating count of words with err_type 3.
- sbe_sticky  out  1  set by any correctable error; cleared by cnt_clear.
- dbe_sticky  out  1  set by any uncorrectable error; cleared by cnt_clear.

## Operation
- Check bits are recomputed from dec_in using the same H-matrix as the encoder.
- Data bit positions in the H-matrix (standard Hamming placement):
  - bits 0..3 → positions 3, 5, 6, 7
  - bits 4..10 → positions 9..15
  - bits 11..25 → positions 17..31
  - bits 26..31 → positions 33..38
- syndrome[5:0] = recomputed[5:0] XOR parity_in[5:0].
- ovp = XOR of all 32 bits of dec_in and all 7 bits of parity_in (1 = odd).
- Classification:
  - syndrome = 0, ovp = 0 → clean (err_type 0).
  - syndrome = 0, ovp = 1 → parity_in[6] in error; err_type 2.
  - syndrome ≠ 0, ovp = 1:
    - syndrome is a power of two (1, 2, 4, 8, 16, 32) → check bit in error; err_type 2.
    - syndrome is a data position → that data bit is flipped; err_type 1.
    - syndrome is any other value (0x27..0x3F) → err_type 3.
  - syndrome ≠ 0, ovp = 0 → double error; err_type 3.
- On err_type 3, dec_out carries dec_in unmodified.
- Counters:
  - Each counter increments by 1 per out_valid word of its class.
  - Each counter holds at 2^CNT_W−1.
  - cnt_clear has priority: if an error word completes in the same cycle as cnt_clear, the counters become 0 and that error is not counted.
- Sticky flags follow the same update and clear rules as the counters.
- There is no backpressure. A new word may be accepted on every cycle.

## Timing
- Stage 1: register dec_in, syndrome, ovp and valid.
- Stage 2: register corrected word, err_type and syndrome_out, and assert out_valid.
- Latency: in_valid at edge N → out_valid at edge N+2. Counters and sticky flags change at that same edge N+2.
- Throughput: 1 word per clock. Back-to-back and gapped input streams are both handled.
- Outputs while out_valid = 0:
  - dec_out, syndrome_out and err_type hold their last values.
  - The counters never change.
- Reset values (all outputs 0): dec_out = 0, syndrome_out = 0, err_type = 0, out_valid = 0, sbe_count = 0, dbe_count = 0, sbe_sticky = 0, dbe_sticky = 0.
- Reset asserted mid-stream: all words in flight are discarded and no out_valid is produced for them. The pipeline resumes 2 cycles after the first in_valid following reset release.

## Structure
- ecc32_pkg holds:
  - function ecc32_chk(data[31:0]) → [5:0], shared with the encoder.
  - function ecc32_pos2bit(syndrome) → {hit, index[4:0]}.
  - err_type localparams: ECC_OK, ECC_DFIX, ECC_CFIX, ECC_UNCOR.
- Sub-module ecc32_syndrome: combinational; produces syndrome[5:0] and ovp from (data, parity). Instantiated in stage 1.
- The counters and sticky flags are written inline in ecc32_decoder.

## Test plan
- Clean words: 0x00000000 with parity 0x00, then 0xDEADBEEF with its encoder parity. Required: dec_out equal to the input, err_type 0, syndrome_out 0x00, out_valid exactly 2 cycles after in_valid.
- Single data-bit error: encode 0xDEADBEEF, flip data bit 0. Required: syndrome[5:0] = 0x03, ovp = 1, dec_out = 0xDEADBEEF, err_type 1, sbe_count = 1.
- Check-bit errors: flip parity_in[6] only. Required: syndrome_out = 0x40, err_type 2, data unchanged. Then flip parity_in[5] only. Required: syndrome[5:0] = 0x20, err_type 2.
- Double error: encode 0x12345678, flip data bits 0 and 1. Required: syndrome[5:0] = 0x06, ovp = 0, err_type 3, dec_out equal to the corrupted input, dbe_count = 1, dbe_sticky = 1.
- Counter limits, with CNT_W = 4:
  - 17 back-to-back single errors → sbe_count = 15.
  - cnt_clear in the same cycle as an error word's out_valid → 0.
- Reset mid-stream: assert reset_n = 0 for 1 cycle with 2 words in flight. Required: no out_valid for those words, all outputs 0, and the next word decodes normally.
